// File: rtl/cfeb_data_rcvr.sv
`default_nettype none
// ============================================================================
//  Module      : cfeb_data_rcvr
//  Description : Receiver for the CFEB readout link. Registers the strobed
//                16-bit word stream, delimits frames with ENDWORD or an idle
//                timeout, checks word count and the trailing CRC-16 (0x8005),
//                and writes {err, last, word} into a downstream FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module cfeb_data_rcvr #(
    parameter int FRAME_WORDS = 96,
    parameter int TIMEOUT     = 255
) (
    input  logic        CLK25,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic        LPUSH_B,
    input  logic        ENDWORD,
    input  logic        FIFO_FULL,
    output logic        FIFO_WE,
    output logic [17:0] FIFO_DATA,
    output logic        FRAME_DONE,
    output logic        CRC_ERR,
    output logic        WC_ERR,
    output logic        TMO_ERR,
    output logic        OVFL,
    output logic [11:0] FRAME_CNT,
    output logic [7:0]  ERR_CNT
);

    localparam logic [11:0] c_frame_words = 12'(FRAME_WORDS);
    localparam logic [15:0] c_timeout     = 16'(TIMEOUT);
    localparam logic [15:0] c_poly        = 16'h8005;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_s1_data;
    logic        r_s1_strobe;
    logic        r_s1_end;

    logic [15:0] r_crc;
    logic [11:0] r_word_cnt;
    logic        r_drop;
    logic [15:0] r_idle_cnt;

    logic        w_data_word;
    logic        w_end_word;
    logic        w_timeout;
    logic        w_close;
    logic        w_write;
    logic        w_crc_bad;
    logic        w_wc_bad;
    logic        w_frame_err;
    logic [15:0] w_crc_next;
    logic [17:0] w_fifo_word;

    // One data word folded into the CRC, MSB first, bit-serial in one cycle.
    function automatic logic [15:0] f_crc_word(input logic [15:0] crc_in,
                                               input logic [15:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? c_poly : 16'h0000);
        end
        return c;
    endfunction

    // Input stage: every decision below is taken on these registered copies.
    always_ff @(posedge CLK25) begin
        if (RST) begin
            r_s1_data   <= 16'h0000;
            r_s1_strobe <= 1'b0;
            r_s1_end    <= 1'b0;
        end else begin
            r_s1_data   <= DATA;
            r_s1_strobe <= ~LPUSH_B;
            r_s1_end    <= ENDWORD;
        end
    end

    // Word classification and frame-close conditions. A strobe in the cycle
    // the idle counter matures suppresses the timeout, so ENDWORD wins.
    always_comb begin
        w_data_word = r_s1_strobe & ~r_s1_end;
        w_end_word  = r_s1_strobe &  r_s1_end;
        w_timeout   = (r_state == ST_RECV) && !r_s1_strobe && (r_idle_cnt == c_timeout);
        w_close     = w_end_word | w_timeout;
        w_write     = w_data_word | w_close;
        w_crc_next  = f_crc_word(r_crc, r_s1_data);
        w_crc_bad   = (r_s1_data != r_crc);
        w_wc_bad    = (r_word_cnt != c_frame_words);
        // A closing word that is itself dropped still marks the frame bad.
        w_frame_err = w_timeout | w_crc_bad | w_wc_bad | r_drop | FIFO_FULL;
        if (w_timeout) begin
            w_fifo_word = {2'b11, 16'h0000};
        end else if (w_end_word) begin
            w_fifo_word = {w_frame_err, 1'b1, r_s1_data};
        end else begin
            w_fifo_word = {2'b00, r_s1_data};
        end
    end

    // State register.
    always_ff @(posedge CLK25) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a data word opens a frame, ENDWORD or timeout closes it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_data_word) w_state_next = ST_RECV;
            ST_RECV: if (w_close)     w_state_next = ST_IDLE;
            default:                  w_state_next = ST_IDLE;
        endcase
    end

    // Per-frame tracking: running CRC, word count, drop flag, idle counter.
    always_ff @(posedge CLK25) begin
        if (RST) begin
            r_crc      <= 16'h0000;
            r_word_cnt <= 12'd0;
            r_drop     <= 1'b0;
            r_idle_cnt <= 16'd0;
        end else if (w_close) begin
            r_crc      <= 16'h0000;
            r_word_cnt <= 12'd0;
            r_drop     <= 1'b0;
            r_idle_cnt <= 16'd0;
        end else if (w_data_word) begin
            r_crc      <= w_crc_next;
            r_word_cnt <= (r_word_cnt == 12'hFFF) ? r_word_cnt : r_word_cnt + 12'd1;
            r_drop     <= r_drop | FIFO_FULL;
            r_idle_cnt <= 16'd0;
        end else if (r_state == ST_RECV) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    // Registered FIFO write port and frame status/statistics.
    always_ff @(posedge CLK25) begin
        if (RST) begin
            FIFO_WE    <= 1'b0;
            FIFO_DATA  <= 18'h00000;
            FRAME_DONE <= 1'b0;
            CRC_ERR    <= 1'b0;
            WC_ERR     <= 1'b0;
            TMO_ERR    <= 1'b0;
            OVFL       <= 1'b0;
            FRAME_CNT  <= 12'd0;
            ERR_CNT    <= 8'd0;
        end else begin
            FIFO_WE    <= 1'b0;
            FRAME_DONE <= 1'b0;
            if (w_write) begin
                FIFO_DATA <= w_fifo_word;
                if (FIFO_FULL) begin
                    OVFL <= 1'b1;
                end else begin
                    FIFO_WE <= 1'b1;
                end
            end
            if (w_close) begin
                FRAME_DONE <= 1'b1;
                FRAME_CNT  <= FRAME_CNT + 12'd1;
                CRC_ERR    <= w_end_word & w_crc_bad;
                WC_ERR     <= w_timeout | w_wc_bad;
                TMO_ERR    <= w_timeout;
                if (w_frame_err && (ERR_CNT != 8'hFF)) begin
                    ERR_CNT <= ERR_CNT + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cfeb_data_rcvr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cfeb_data_rcvr
//  Description : Directed self-checking bench for cfeb_data_rcvr. FIFO writes
//                are checked against a scoreboard queue filled at stimulus
//                time; frame status is checked at each frame close.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cfeb_data_rcvr;

    logic        clk;
    logic        rst;
    logic [15:0] data;
    logic        lpush_b;
    logic        endword;
    logic        fifo_full;

    logic        fifo_we,    d2_fifo_we;
    logic [17:0] fifo_data,  d2_fifo_data;
    logic        frame_done, d2_frame_done;
    logic        crc_err,    d2_crc_err;
    logic        wc_err,     d2_wc_err;
    logic        tmo_err,    d2_tmo_err;
    logic        ovfl,       d2_ovfl;
    logic [11:0] frame_cnt,  d2_frame_cnt;
    logic [7:0]  err_cnt,    d2_err_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] sb[$];
    int          fc = 0;
    int          ec = 0;

    cfeb_data_rcvr #(.FRAME_WORDS(1), .TIMEOUT(4)) dut (
        .CLK25(clk), .RST(rst), .DATA(data), .LPUSH_B(lpush_b), .ENDWORD(endword),
        .FIFO_FULL(fifo_full), .FIFO_WE(fifo_we), .FIFO_DATA(fifo_data),
        .FRAME_DONE(frame_done), .CRC_ERR(crc_err), .WC_ERR(wc_err), .TMO_ERR(tmo_err),
        .OVFL(ovfl), .FRAME_CNT(frame_cnt), .ERR_CNT(err_cnt)
    );

    cfeb_data_rcvr #(.FRAME_WORDS(2), .TIMEOUT(4)) dut_fw2 (
        .CLK25(clk), .RST(rst), .DATA(data), .LPUSH_B(lpush_b), .ENDWORD(endword),
        .FIFO_FULL(fifo_full), .FIFO_WE(d2_fifo_we), .FIFO_DATA(d2_fifo_data),
        .FRAME_DONE(d2_frame_done), .CRC_ERR(d2_crc_err), .WC_ERR(d2_wc_err),
        .TMO_ERR(d2_tmo_err), .OVFL(d2_ovfl), .FRAME_CNT(d2_frame_cnt), .ERR_CNT(d2_err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #12.5 clk = ~clk;
    end

    // Reference CRC-16 0x8005, init 0, MSB first.
    function automatic logic [15:0] m_crc(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int b = 15; b >= 0; b--) begin
            if (r[15] != d[b]) r = (r << 1) ^ 16'h8005;
            else               r = r << 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic stb, input logic [15:0] d, input logic e, input logic full);
        @(posedge clk);
        #1;
        lpush_b   = ~stb;
        data      = d;
        endword   = e;
        fifo_full = full;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic push_data(input logic [15:0] d);
        drive(1'b1, d, 1'b0, 1'b0);
        sb.push_back({2'b00, d});
    endtask

    task automatic push_end(input logic [15:0] d, input logic err);
        drive(1'b1, d, 1'b1, 1'b0);
        sb.push_back({err, 1'b1, d});
    endtask

    task automatic count_close(input logic err);
        fc = (fc + 1) % 4096;
        if (err && ec < 255) ec++;
    endtask

    // Called at the negedge on which the close is visible.
    task automatic close_check(input string tag, input logic ce, input logic we, input logic te);
        chk({tag, "_done"},  32'(frame_done), 32'd1);
        chk({tag, "_crc"},   32'(crc_err),    32'(ce));
        chk({tag, "_wc"},    32'(wc_err),     32'(we));
        chk({tag, "_tmo"},   32'(tmo_err),    32'(te));
        chk({tag, "_fcnt"},  32'(frame_cnt),  32'(fc));
        chk({tag, "_ecnt"},  32'(err_cnt),    32'(ec));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(frame_done), 32'd0);
    endtask

    task automatic wait_close();
        idle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] crc2;
        rst = 1'b1; data = 16'h0000; lpush_b = 1'b1; endword = 1'b0; fifo_full = 1'b0;

        // Scoreboard: every FIFO write must match the oldest expected word.
        fork
            forever begin
                logic [17:0] exp_w;
                @(negedge clk);
                if (fifo_we === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL fifo_unexpected observed=0x%0h expected=no_write", fifo_data);
                    end else begin
                        exp_w = sb.pop_front();
                        chk("fifo_data", 32'(fifo_data), 32'(exp_w));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_we",   32'(fifo_we),    32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt),  32'd0);
        chk("rst_ecnt", 32'(err_cnt),    32'd0);
        chk("rst_ovfl", 32'(ovfl),       32'd0);
        chk("rst_data", 32'(fifo_data),  32'd0);

        // Good one-word frame; the FRAME_WORDS=2 instance sees a short frame.
        push_data(16'h0001);
        push_end(16'h8005, 1'b0);
        wait_close();
        count_close(1'b0);
        chk("fw2_we",   32'(d2_fifo_we),   32'd1);
        chk("fw2_data", 32'(d2_fifo_data), 32'h38005);
        chk("fw2_wc",   32'(d2_wc_err),    32'd1);
        chk("fw2_crc",  32'(d2_crc_err),   32'd0);
        close_check("good", 1'b0, 1'b0, 1'b0);

        // Bad CRC word.
        push_data(16'h0001);
        push_end(16'h8004, 1'b1);
        wait_close();
        count_close(1'b1);
        close_check("badcrc", 1'b1, 1'b0, 1'b0);

        // ENDWORD landing in the cycle the timeout would mature.
        push_data(16'h0001);
        repeat (4) idle();
        push_end(16'h8005, 1'b0);
        wait_close();
        count_close(1'b0);
        close_check("endwins", 1'b0, 1'b0, 1'b0);

        // Timeout: filler written 7 cycles after the last strobed input.
        push_data(16'h1234);
        sb.push_back(18'h30000);
        idle();
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("tmo_early", 32'(frame_done), 32'd0);
        @(negedge clk);
        count_close(1'b1);
        close_check("tmo", 1'b0, 1'b1, 1'b1);

        // FIFO full while the second data word is written: dropped, OVFL set.
        crc2 = m_crc(m_crc(16'h0000, 16'h0001), 16'h0002);
        push_data(16'h0001);
        drive(1'b1, 16'h0002, 1'b0, 1'b0);
        drive(1'b1, crc2, 1'b1, 1'b1);
        sb.push_back({2'b11, crc2});
        wait_close();
        count_close(1'b1);
        chk("ovfl_set", 32'(ovfl), 32'd1);
        close_check("ovfl", 1'b0, 1'b1, 1'b0);

        // Next good frame: drop flag cleared, OVFL sticky.
        push_data(16'h0001);
        push_end(16'h8005, 1'b0);
        wait_close();
        count_close(1'b0);
        chk("ovfl_sticky", 32'(ovfl), 32'd1);
        close_check("after_ovfl", 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a frame.
        push_data(16'h0001);
        push_data(16'h0002);
        push_data(16'h0003);
        idle();
        idle();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        fc = 0;
        ec = 0;
        @(negedge clk);
        chk("mrst_done", 32'(frame_done), 32'd0);
        chk("mrst_fcnt", 32'(frame_cnt),  32'd0);
        chk("mrst_ovfl", 32'(ovfl),       32'd0);
        push_data(16'h0001);
        push_end(16'h8005, 1'b0);
        wait_close();
        count_close(1'b0);
        close_check("post_rst", 1'b0, 1'b0, 1'b0);

        // 256 empty frames with a wrong CRC word: ERR_CNT saturates.
        for (int k = 0; k < 256; k++) begin
            push_end(16'h0001, 1'b1);
            count_close(1'b1);
        end
        wait_close();
        chk("sat_ecnt", 32'(err_cnt),   32'(ec));
        chk("sat_255",  32'(err_cnt),   32'd255);
        chk("sat_fcnt", 32'(frame_cnt), 32'(fc));

        repeat (4) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
